// File: rtl/vga_frame_reader_pkg.sv
// Shared display definitions: reader FSM encoding, AXI burst/size constants and beat size.
package vga_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0]  AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned BEAT_BYTES     = 8;

endpackage

// File: rtl/vga_frame_reader.sv
// Looping AXI frame-buffer reader: issues fixed-length INCR bursts over a frame and
// forwards read data straight to the display consumer.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int BURST_BEATS     = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [31:0] frame_base,
  input  logic [19:0] frame_beats,
  output logic [31:0] M_AXI_ARADDR,
  output logic [3:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic [63:0] sdata,
  output logic        sdata_valid,
  input  logic        sdata_ready,
  input  logic        sdata_burst_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        err_resp
);

  localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]   MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]   ONE     = OW'(1);
  localparam logic [31:0]     STRIDE  = 32'(BURST_BEATS * BEAT_BYTES);

  state_t        state;
  logic [31:0]   base_q;
  logic [19:0]   last_idx;
  logic [19:0]   ar_idx;
  logic [19:0]   rd_idx;
  logic [OW-1:0] outstanding;
  logic          stop_pending;
  logic          ar_hs;
  logic          r_hs;
  logic          rlast_hs;

  assign M_AXI_ARLEN   = 4'(BURST_BEATS - 1);
  assign M_AXI_ARSIZE  = AXI_SIZE_8B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;

  assign sdata        = M_AXI_RDATA;
  assign sdata_valid  = M_AXI_RVALID;
  assign M_AXI_RREADY = sdata_ready;

  assign busy     = (state != ST_IDLE);
  assign ar_hs    = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs     = M_AXI_RVALID & sdata_ready;
  assign rlast_hs = r_hs & M_AXI_RLAST;

  always_ff @(posedge fclk) begin
    if (rst) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      last_idx      <= '0;
      ar_idx        <= '0;
      rd_idx        <= '0;
      outstanding   <= '0;
      stop_pending  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      frame_done    <= 1'b0;
      err_resp      <= 1'b0;
    end else begin
      // Bursts return in issue order, so a read-side index tracks the frame's last burst.
      frame_done <= rlast_hs && (rd_idx == last_idx);
      if (r_hs && (M_AXI_RRESP != 2'b00)) err_resp <= 1'b1;
      if (rlast_hs) rd_idx <= (rd_idx == last_idx) ? '0 : rd_idx + 20'd1;

      case ({ar_hs, rlast_hs})
        2'b10:   outstanding <= outstanding + ONE;
        2'b01:   outstanding <= outstanding - ONE;
        default: ;
      endcase

      if (ar_hs) begin
        M_AXI_ARVALID <= 1'b0;
        if (ar_idx == last_idx) begin
          ar_idx       <= '0;
          M_AXI_ARADDR <= base_q;
        end else begin
          ar_idx       <= ar_idx + 20'd1;
          M_AXI_ARADDR <= M_AXI_ARADDR + STRIDE;
        end
      end

      case (state)
        ST_IDLE: begin
          if (cmd_start && (frame_beats != '0)) begin
            state        <= ST_RUN;
            base_q       <= frame_base;
            last_idx     <= (frame_beats / 20'(BURST_BEATS)) - 20'd1;
            M_AXI_ARADDR <= frame_base;
            ar_idx       <= '0;
            rd_idx       <= '0;
            err_resp     <= 1'b0;
            stop_pending <= 1'b0;
          end
        end
        ST_RUN: begin
          // A raised ARVALID is held until accepted; a stop only takes effect after that.
          if (M_AXI_ARVALID) begin
            if (cmd_stop) stop_pending <= 1'b1;
            if (ar_hs && (cmd_stop || stop_pending)) begin
              state        <= ST_DRAIN;
              stop_pending <= 1'b0;
            end
          end else if (cmd_stop || stop_pending) begin
            state        <= ST_DRAIN;
            stop_pending <= 1'b0;
          end else if (sdata_burst_ready && (outstanding < MAX_OUT)) begin
            M_AXI_ARVALID <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader with a small in-order AXI read slave model.
module tb_vga_frame_reader;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic [31:0] frame_base = '0;
  logic [19:0] frame_beats = '0;
  logic [31:0] M_AXI_ARADDR;
  logic [3:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [63:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RLAST = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;
  logic [63:0] sdata;
  logic        sdata_valid;
  logic        sdata_ready = 1'b1;
  logic        sdata_burst_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic        err_resp;

  vga_frame_reader #(.BURST_BEATS(16), .MAX_OUTSTANDING(2)) dut (
    .fclk(fclk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .frame_base(frame_base), .frame_beats(frame_beats),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .sdata(sdata), .sdata_valid(sdata_valid), .sdata_ready(sdata_ready),
    .sdata_burst_ready(sdata_burst_ready),
    .busy(busy), .frame_done(frame_done), .err_resp(err_resp)
  );

  initial forever #5 fclk = ~fclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave knobs and model state
  bit          ar_ready_en = 1'b1;
  int          r_delay = 2;
  int          err_beat = -1;
  logic [31:0] q_addr[$];
  int          q_rdy[$];
  logic [31:0] ar_log[$];
  int          ar_cyc[$];
  int          rl_cyc[$];
  int          beat_in_burst = 0;
  int          beat_cnt = 0;
  int          cyc = 0;
  int          max_outst = 0;
  int          first_fd_beats = -1;

  // Drive the slave at the falling edge; whatever is valid&ready now is taken at the next rise.
  task automatic step();
    @(negedge fclk);
    cyc++;
    M_AXI_ARREADY = ar_ready_en;
    if (q_addr.size() > 0 && q_rdy[0] <= cyc) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = {q_addr[0], 32'(beat_in_burst)};
      M_AXI_RLAST  = (beat_in_burst == 15);
      M_AXI_RRESP  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
    end else begin
      M_AXI_RVALID = 1'b0;
      M_AXI_RDATA  = '0;
      M_AXI_RLAST  = 1'b0;
      M_AXI_RRESP  = 2'b00;
    end
    #1;
    if (frame_done && first_fd_beats < 0) first_fd_beats = beat_cnt;
    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
      q_addr.push_back(M_AXI_ARADDR);
      q_rdy.push_back(cyc + r_delay);
      ar_log.push_back(M_AXI_ARADDR);
      ar_cyc.push_back(cyc);
    end
    if (M_AXI_RVALID && M_AXI_RREADY) begin
      beat_cnt++;
      if (M_AXI_RLAST) begin
        void'(q_addr.pop_front());
        void'(q_rdy.pop_front());
        beat_in_burst = 0;
        rl_cyc.push_back(cyc);
      end else begin
        beat_in_burst++;
      end
    end
    if (ar_log.size() - rl_cyc.size() > max_outst) max_outst = ar_log.size() - rl_cyc.size();
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [19:0] beats);
    frame_base  = base;
    frame_beats = beats;
    cmd_start   = 1'b1;
    step();
    cmd_start   = 1'b0;
  endtask

  task automatic stop_and_drain(input string tag);
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      step();
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    int  a0;
    int  l0;
    int  b0;
    bit  seen;
    bit  stable;
    int  arv;

    // Reset state
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_arvalid", M_AXI_ARVALID, 1'b0);
    check("rst_araddr", M_AXI_ARADDR, 32'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err_resp", err_resp, 1'b0);
    rst = 1'b0;
    step();
    check("const_arlen", M_AXI_ARLEN, 4'd15);
    check("const_arsize", M_AXI_ARSIZE, 3'b011);
    check("const_arburst", M_AXI_ARBURST, 2'b01);
    check("idle_after_rst", busy, 1'b0);

    // Two-burst frame: addresses step by 0x80 then wrap; frame_done after beat 32
    pulse_start(32'h1000_0000, 20'd32);
    check("t1_busy", busy, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ar_log.size() >= 3 && first_fd_beats >= 0) break;
      step();
      if (!seen && M_AXI_RVALID) begin
        seen = 1'b1;
        check("t1_sdata", sdata, 64'h1000_0000_0000_0000);
        check("t1_sdata_valid", sdata_valid, 1'b1);
        check("t1_rready", M_AXI_RREADY, 1'b1);
      end
    end
    check("t1_addr0", (ar_log.size() > 0) ? ar_log[0] : 32'hDEAD, 32'h1000_0000);
    check("t1_addr1", (ar_log.size() > 1) ? ar_log[1] : 32'hDEAD, 32'h1000_0080);
    check("t1_addr2_wrap", (ar_log.size() > 2) ? ar_log[2] : 32'hDEAD, 32'h1000_0000);
    check("t1_frame_done_beat", 64'(first_fd_beats), 64'd32);
    stop_and_drain("t1_idle");
    check("t1_all_data", 64'(beat_cnt), 64'(ar_log.size() * 16));

    // Consumer back-pressure blocks AR issue until released
    sdata_burst_ready = 1'b0;
    pulse_start(32'h3000_0000, 20'd16);
    arv = 0;
    repeat (50) begin
      step();
      if (M_AXI_ARVALID) arv++;
    end
    check("t2_no_arvalid", 64'(arv), 64'd0);
    check("t2_busy", busy, 1'b1);
    sdata_burst_ready = 1'b1;
    step();
    check("t2_arvalid_next", M_AXI_ARVALID, 1'b1);
    check("t2_araddr", M_AXI_ARADDR, 32'h3000_0000);
    stop_and_drain("t2_idle");

    // Slow read data: never more than two bursts in flight
    r_delay   = 20;
    max_outst = 0;
    a0 = ar_log.size();
    l0 = rl_cyc.size();
    pulse_start(32'h4000_0000, 20'd64);
    for (int i = 0; i < 300; i++) begin
      if (ar_log.size() >= a0 + 3) break;
      step();
    end
    check("t3_max_outstanding", 64'(max_outst), 64'd2);
    check("t3_third_after_rlast",
          (ar_log.size() > a0 + 2 && rl_cyc.size() > l0) ? (ar_cyc[a0+2] > rl_cyc[l0]) : 1'b0, 1'b1);
    check("t3_addr2", (ar_log.size() > a0 + 2) ? ar_log[a0+2] : 32'hDEAD, 32'h4000_0100);
    stop_and_drain("t3_idle");
    check("t3_outstanding_bound", 64'(max_outst), 64'd2);
    r_delay = 2;

    // Stop while AR is stalled: address held, AR completes, drain then idle
    ar_ready_en = 1'b0;
    a0 = ar_log.size();
    pulse_start(32'h2000_0000, 20'd32);
    for (int i = 0; i < 20; i++) begin
      if (M_AXI_ARVALID) break;
      step();
    end
    check("t4_arvalid", M_AXI_ARVALID, 1'b1);
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    stable = 1'b1;
    repeat (5) begin
      step();
      if (!M_AXI_ARVALID || M_AXI_ARADDR !== 32'h2000_0000) stable = 1'b0;
    end
    check("t4_ar_stable", stable, 1'b1);
    ar_ready_en = 1'b1;
    b0 = beat_cnt;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy) break;
    end
    check("t4_idle", busy, 1'b0);
    check("t4_one_ar", 64'(ar_log.size() - a0), 64'd1);
    check("t4_beats_before_idle", 64'(beat_cnt - b0), 64'd16);
    check("t4_arvalid_low", M_AXI_ARVALID, 1'b0);

    // Error response is sticky until the next accepted start
    err_beat = beat_cnt + 5;
    l0 = rl_cyc.size();
    pulse_start(32'h5000_0000, 20'd16);
    for (int i = 0; i < 100; i++) begin
      if (rl_cyc.size() > l0) break;
      step();
    end
    check("t5_err_set", err_resp, 1'b1);
    stop_and_drain("t5_idle");
    err_beat = -1;
    check("t5_err_sticky", err_resp, 1'b1);
    pulse_start(32'h5000_0000, 20'd0);
    step();
    check("t5_zero_start_idle", busy, 1'b0);
    check("t5_zero_start_err", err_resp, 1'b1);
    cmd_stop = 1'b1;
    pulse_start(32'h5000_0000, 20'd16);
    cmd_stop = 1'b0;
    check("t5_start_stop_runs", busy, 1'b1);
    check("t5_err_cleared", err_resp, 1'b0);
    stop_and_drain("t5_final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
